// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM window counter.
// State encoding, default sizes and a width helper.
package pdm_pkg;

  localparam int unsigned CNT_W_DEF  = 10;
  localparam int unsigned WINDOW_DEF = 1000;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pdm_delay_line.sv
// WINDOW-bit shift register with enable; oldest is the bit
// accepted DEPTH shifts ago.
module pdm_delay_line #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic oldest
);

  logic [DEPTH-1:0] sh_q;
  logic [DEPTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (en) sh_d = {sh_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign oldest = sh_q[DEPTH-1];

endmodule

// File: rtl/pdm_window_counter.sv
// Ones counter over a window of accepted PDM samples.
// Define PDM_SLIDING_WIN_EN for a decimated sliding window.
module pdm_window_counter
  import pdm_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DECIM  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_data,
  input  logic             pdm_valid,
  output logic [CNT_W-1:0] cntr,
  output logic             cntr_valid
);

  localparam int unsigned IDX_W = clog2(WINDOW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);

  if (WINDOW < 2 || WINDOW > (2 ** CNT_W) - 1) begin : g_bad_window
    $error("pdm_window_counter: WINDOW out of range for CNT_W");
  end
  if (DECIM < 1 || DECIM > WINDOW) begin : g_bad_decim
    $error("pdm_window_counter: DECIM out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic             vld_q, vld_d;

`ifdef PDM_SLIDING_WIN_EN
  localparam int unsigned DEC_W = clog2(DECIM);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  logic [DEC_W-1:0] dec_q, dec_d;
  logic [CNT_W-1:0] sum_q, sum_d;
  logic             oldest;

  pdm_delay_line #(
    .DEPTH (WINDOW)
  ) u_dly (
    .clk    (clk),
    .rst    (rst),
    .en     (pdm_valid),
    .din    (pdm_data),
    .oldest (oldest)
  );
`else
  logic [CNT_W-1:0] acc_q, acc_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cntr_d  = cntr_q;
    vld_d   = 1'b0;
`ifdef PDM_SLIDING_WIN_EN
    dec_d   = dec_q;
    sum_d   = sum_q;
    if (pdm_valid) begin
      // the bit leaving the window only exists once the line is full
      sum_d = sum_q + CNT_W'(pdm_data)
            - ((state_q == ST_RUN) ? CNT_W'(oldest) : '0);
      if (state_q == ST_FILL) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cntr_d  = sum_d;
          vld_d   = 1'b1;
          state_d = ST_RUN;
          dec_d   = '0;
        end
      end else begin
        dec_d = dec_q + 1'b1;
        if (dec_q == DEC_LAST) begin
          dec_d  = '0;
          cntr_d = sum_d;
          vld_d  = 1'b1;
        end
      end
    end
`else
    acc_d = acc_q;
    if (pdm_valid) begin
      idx_d = idx_q + 1'b1;
      acc_d = acc_q + CNT_W'(pdm_data);
      if (idx_q == IDX_LAST) begin
        cntr_d  = acc_q + CNT_W'(pdm_data);
        vld_d   = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
        state_d = ST_RUN;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      cntr_q  <= '0;
      vld_q   <= 1'b0;
`ifdef PDM_SLIDING_WIN_EN
      dec_q   <= '0;
      sum_q   <= '0;
`else
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cntr_q  <= cntr_d;
      vld_q   <= vld_d;
`ifdef PDM_SLIDING_WIN_EN
      dec_q   <= dec_d;
      sum_q   <= sum_d;
`else
      acc_q   <= acc_d;
`endif
    end
  end

  assign cntr       = cntr_q;
  assign cntr_valid = vld_q;

endmodule

// File: tb/tb_pdm_window_counter.sv
// Randomized and directed bench for pdm_window_counter.
// Reference model keeps the accepted-sample history in a queue.
module tb_pdm_window_counter;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pdm_data = 1'b0;
  logic          pdm_valid = 1'b0;
  logic [CW-1:0] cntr;
  logic          cntr_valid;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            hist[$];
  bit            exp_vld;
  logic [CW-1:0] exp_cntr;
  int            cyc;

  always #1 clk = ~clk;

  pdm_window_counter #(
    .WINDOW (W),
    .CNT_W  (CW),
    .DECIM  (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pdm_data   (pdm_data),
    .pdm_valid  (pdm_valid),
    .cntr       (cntr),
    .cntr_valid (cntr_valid)
  );

  function automatic bit strobe_due(input int n);
`ifdef PDM_SLIDING_WIN_EN
    return (n >= W) && (((n - W) % DC) == 0);
`else
    return (n > 0) && ((n % W) == 0);
`endif
  endfunction

  // drive one cycle, advance the model, sample 1 ns after the edge
  task automatic step(input bit v, input bit d, input bit r);
    int s;
    rst = r;
    pdm_valid = v;
    pdm_data = d;
    @(posedge clk);
    exp_vld = 1'b0;
    if (r) begin
      hist.delete();
      exp_cntr = '0;
    end else if (v) begin
      hist.push_back(int'(d));
      if (strobe_due(hist.size())) begin
        s = 0;
        for (int i = hist.size() - W; i < hist.size(); i++) s += hist[i];
        exp_vld = 1'b1;
        exp_cntr = CW'(s);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
    n_cmp++;
    if (cntr_valid !== 1'b0 || cntr !== '0) begin
      n_bad++;
      $display("FAIL reset: vld=%b cntr=%0d want vld=0 cntr=0",
               cntr_valid, cntr);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    int hits = 0;
    int at = -1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(i < 8, 1'b1, 1'b0);
      n_cmp++;
      if (cntr_valid !== exp_vld || cntr !== exp_cntr) begin
        n_bad++;
        $display("FAIL all_ones c%0d: vld=%b cntr=%0d want %b/%0d",
                 cyc, cntr_valid, cntr, exp_vld, exp_cntr);
      end
      if (cntr_valid === 1'b1) begin
        hits++;
        at = cyc;
      end
    end
    n_cmp++;
    if (hits != 1 || at != 8 || cntr !== 4'd8) begin
      n_bad++;
      $display("FAIL all_ones_pulse: hits=%0d at=%0d cntr=%0d want 1/8/8",
               hits, at, cntr);
    end
  endtask

  task automatic test_alternating();
    int at[$];
    do_reset();
    for (int i = 0; i < 3 * W; i++) begin
      step(1'b1, ~i[0], 1'b0);
      n_cmp++;
      if (cntr_valid !== exp_vld || cntr !== exp_cntr) begin
        n_bad++;
        $display("FAIL alternating c%0d: vld=%b cntr=%0d want %b/%0d",
                 cyc, cntr_valid, cntr, exp_vld, exp_cntr);
      end
      if (cntr_valid === 1'b1) at.push_back(cyc);
    end
`ifndef PDM_SLIDING_WIN_EN
    n_cmp++;
    if (at.size() != 3 || at[0] != 8 || at[1] != 16 || at[2] != 24
        || cntr !== 4'd4) begin
      n_bad++;
      $display("FAIL alternating_spacing: strobes=%0d cntr=%0d want 3 at 8/16/24 cntr=4",
               at.size(), cntr);
    end
`endif
  endtask

  task automatic test_reset_midwindow();
    int pre = 0;
    int first = -1;
    logic [CW-1:0] fval = '1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (cntr_valid === 1'b1) pre++;
    end
    step(1'b0, 1'b1, 1'b1);
    cyc = 0;
    for (int i = 0; i < 9; i++) begin
      step(i < 8, 1'b0, 1'b0);
      n_cmp++;
      if (cntr_valid !== exp_vld || cntr !== exp_cntr) begin
        n_bad++;
        $display("FAIL reset_mid c%0d: vld=%b cntr=%0d want %b/%0d",
                 cyc, cntr_valid, cntr, exp_vld, exp_cntr);
      end
      if (cntr_valid === 1'b1 && first < 0) begin
        first = cyc;
        fval = cntr;
      end
    end
    n_cmp++;
    if (pre != 0 || first != 8 || fval !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_first: pre=%0d first=%0d val=%0d want 0/8/0",
               pre, first, fval);
    end
  endtask

  task automatic test_gapped();
    bit [7:0] pat = 8'b1111_0000;
    int k = 0;
    do_reset();
    for (int i = 0; i < 3 * W + 2; i++) begin
      if ((i % 3) == 2 && k < 8) begin
        step(1'b1, pat[7 - k], 1'b0);
        k++;
      end else begin
        step(1'b0, i[0], 1'b0);
      end
      n_cmp++;
      if (cntr_valid !== exp_vld || cntr !== exp_cntr) begin
        n_bad++;
        $display("FAIL gapped c%0d: vld=%b cntr=%0d want %b/%0d",
                 cyc, cntr_valid, cntr, exp_vld, exp_cntr);
      end
    end
    n_cmp++;
    if (cntr !== 4'd4) begin
      n_bad++;
      $display("FAIL gapped_value: cntr=%0d want 4", cntr);
    end
  endtask

  task automatic test_rst_coincident();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (cntr_valid !== 1'b0 || cntr !== '0) begin
      n_bad++;
      $display("FAIL rst_coincident: vld=%b cntr=%0d want 0/0",
               cntr_valid, cntr);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (cntr_valid !== 1'b0 || cntr !== '0) begin
      n_bad++;
      $display("FAIL rst_coincident_after: vld=%b cntr=%0d want 0/0",
               cntr_valid, cntr);
    end
  endtask

`ifdef PDM_SLIDING_WIN_EN
  task automatic test_sliding();
    int vals[$];
    int ats[$];
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(i < 16, i < 8, 1'b0);
      if (cntr_valid === 1'b1) begin
        vals.push_back(int'(cntr));
        ats.push_back(cyc);
      end
    end
    n_cmp++;
    if (vals.size() != 5) begin
      n_bad++;
      $display("FAIL sliding_count: strobes=%0d want 5", vals.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (vals[i] != 8 - 2 * i || ats[i] != 8 + 2 * i) begin
          n_bad++;
          $display("FAIL sliding_%0d: cntr=%0d at=%0d want %0d at %0d",
                   i, vals[i], ats[i], 8 - 2 * i, 8 + 2 * i);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    bit prev = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
           $urandom_range(0, 99) == 0);
      n_cmp++;
      if (cntr_valid !== exp_vld || cntr !== exp_cntr) begin
        n_bad++;
        $display("FAIL random c%0d: vld=%b cntr=%0d want %b/%0d",
                 cyc, cntr_valid, cntr, exp_vld, exp_cntr);
      end
      if (prev && cntr_valid === 1'b1) begin
        n_bad++;
        $display("FAIL random_double c%0d: vld high twice want single", cyc);
      end
      prev = (cntr_valid === 1'b1);
    end
  endtask

  initial begin
    cyc = 0;
    exp_vld = 1'b0;
    exp_cntr = '0;
    test_reset();
    test_all_ones();
    test_alternating();
    test_reset_midwindow();
    test_gapped();
    test_rst_coincident();
`ifdef PDM_SLIDING_WIN_EN
    test_sliding();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
